// File: rtl/risc_datapath_if.sv
// risc_datapath_if: bus bundle between control unit, external ALU, memory/COM buses and risc_datapath
// master: control/ALU/memory side drives decode fields, ALU results and read data
// slave: datapath drives ALU operands, mem_wr, pc, carry, interrupt status and stk_err
interface risc_datapath_if #(
  parameter int WORD = 8,
  parameter int NREG = 4,
  parameter int PCW = 16,
  parameter int IMMW = 24
);
  localparam int RA = $clog2(NREG);
  logic interrupt;
  logic [RA-1:0] a1, a2, a3;
  logic rw_en;
  logic [1:0] selb;
  logic [2:0] selr;
  logic [1:0] isize;
  logic [2:0] pc_op;
  logic br_take;
  logic carry_upd;
  logic [IMMW-1:0] imm;
  logic [WORD-1:0] alu_a, alu_b, alu_r, alu_rhi;
  logic alu_cout, alu_cin;
  logic [2*WORD-1:0] mem_rd, mem_wr;
  logic [WORD-1:0] com_rd;
  logic [PCW-1:0] pc;
  logic intr_ack, in_isr, stk_err;
  modport master (
    output interrupt, a1, a2, a3, rw_en, selb, selr, isize, pc_op, br_take, carry_upd, imm,
           alu_r, alu_rhi, alu_cout, mem_rd, com_rd,
    input alu_a, alu_b, alu_cin, mem_wr, pc, intr_ack, in_isr, stk_err
  );
  modport slave (
    input interrupt, a1, a2, a3, rw_en, selb, selr, isize, pc_op, br_take, carry_upd, imm,
          alu_r, alu_rhi, alu_cout, mem_rd, com_rd,
    output alu_a, alu_b, alu_cin, mem_wr, pc, intr_ack, in_isr, stk_err
  );
endinterface

// File: rtl/risc_datapath.sv
// risc_datapath: register file, carry, PC unit with return stack and interrupt entry/exit, one instruction per clock
// ports: clk, rst (sync active-low), bus (risc_datapath_if.slave: decode fields, ALU, memory, COM, pc and status)
// DATAPATH_INTR_EN enables interrupt entry/RETI; otherwise intr_ack/in_isr are 0, selr=6 writes 0, RETI acts as SEQ
module risc_datapath #(
  parameter int WORD = 8,
  parameter int NREG = 4,
  parameter int PCW = 16,
  parameter int IMMW = 24,
  parameter int STACK_DEPTH = 4,
  parameter logic [15:0] INTR_VEC = 16'h0010
) (
  input logic clk,
  input logic rst,
  risc_datapath_if.slave bus
);
  localparam int SW = $clog2(STACK_DEPTH) + 1;
  localparam int SA = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [WORD-1:0] rf [NREG];
  logic [PCW-1:0] stk [STACK_DEPTH];
  logic [SW-1:0] cnt, cnt_top;
  logic [PCW-1:0] seq, pc_nx, saved_pc;
  logic [WORD-1:0] r1, r2, wb, intr_flag;
  logic carry, carry_nx, saved_carry, fire, reti, push, pop, full, empty, err;
  assign r1 = rf[bus.a1];
  assign r2 = rf[bus.a2];
  assign bus.alu_a = r1;
  assign bus.alu_b = bus.selb == 2'd0 ? r2 : bus.selb == 2'd1 ? '0 : bus.selb == 2'd2 ? WORD'(1) : bus.imm[WORD-1:0];
  assign bus.mem_wr = {r2, r1};
  assign bus.alu_cin = carry;
  assign seq = bus.pc + PCW'(bus.isize) + PCW'(1);
  assign full = cnt == SW'(STACK_DEPTH);
  assign empty = cnt == '0;
  assign cnt_top = cnt - SW'(1);
  assign carry_nx = bus.carry_upd ? bus.alu_cout : carry;
  assign wb = bus.selr == 3'd0 ? bus.mem_rd[WORD-1:0] :
              bus.selr == 3'd1 ? bus.mem_rd[2*WORD-1:WORD] :
              bus.selr == 3'd3 ? bus.alu_rhi :
              bus.selr == 3'd4 ? bus.imm[WORD-1:0] :
              bus.selr == 3'd5 ? bus.com_rd :
              bus.selr == 3'd6 ? intr_flag : bus.alu_r;
  // PCW <= 16, so adding imm[PCW-1:0] equals adding sext(imm[15:0]) modulo 2^PCW
  always_comb begin
    pc_nx = seq;
    push = 1'b0;
    pop = 1'b0;
    err = 1'b0;
    case (bus.pc_op)
      3'd1: pc_nx = bus.br_take ? seq + bus.imm[PCW-1:0] : seq;
      3'd2: pc_nx = bus.imm[PCW-1:0];
      3'd3: begin
        pc_nx = bus.imm[PCW-1:0];
        push = !full;
        err = full;
      end
      3'd4: begin
        pc_nx = empty ? seq : stk[cnt_top[SA-1:0]];
        pop = !empty;
        err = empty;
      end
      3'd5: begin
        pc_nx = reti ? saved_pc : seq;
        err = reti && !bus.in_isr;
      end
      default: pc_nx = seq;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      bus.pc <= '0;
      carry <= 1'b0;
      cnt <= '0;
      bus.stk_err <= 1'b0;
    end else begin
      if (bus.rw_en) rf[bus.a3] <= wb;
      cnt <= push ? cnt + SW'(1) : pop ? cnt_top : cnt;
      carry <= reti ? saved_carry : carry_nx;
      bus.pc <= fire ? INTR_VEC[PCW-1:0] : pc_nx;
      if (err) bus.stk_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (rst && push) stk[cnt[SA-1:0]] <= seq;
`ifdef DATAPATH_INTR_EN
  assign reti = bus.pc_op == 3'd5;
  // entry is blocked by RETI so the return and the next entry never share an edge
  assign fire = rst && bus.interrupt && !bus.in_isr && !reti;
  assign bus.intr_ack = fire;
  always_ff @(posedge clk)
    if (!rst) begin
      saved_pc <= '0;
      saved_carry <= 1'b0;
      intr_flag <= '0;
      bus.in_isr <= 1'b0;
    end else if (fire) begin
      saved_pc <= pc_nx;
      saved_carry <= carry_nx;
      intr_flag <= bus.com_rd;
      bus.in_isr <= 1'b1;
    end else if (reti) begin
      bus.in_isr <= 1'b0;
    end
`else
  assign reti = 1'b0;
  assign fire = 1'b0;
  assign bus.intr_ack = 1'b0;
  assign bus.in_isr = 1'b0;
  assign saved_pc = '0;
  assign saved_carry = 1'b0;
  assign intr_flag = '0;
`endif
endmodule

// File: doc/risc_datapath.md
# risc_datapath

Parametrised successor to the 8-bit RISC datapath. It holds:
- the register file and carry flag;
- a PC unit with conditional relative branch, absolute jump, call/return through a hardware return stack;
- interrupt entry/exit.

It sits between the control unit (decoded fields in), an external ALU (operands out, results in), and the memory/COM buses, one instruction per clock.

## Interface
Parameters:
- WORD, 8, data word width
- NREG, 4, register count (power of two, ≥2)
- PCW, 16, program counter width (≤16)
- IMMW, 24, immediate field width (≥16)
- STACK_DEPTH, 4, return stack entries (power of two)
- INTR_VEC, 16'h0010, interrupt entry address

Ports (RA = $clog2(NREG)):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset (0 = reset)
- interrupt  in  1  level interrupt request
- a1, a2, a3  in  RA  read addr 1/2, write addr
- rw_en  in  1  register write enable
- selb  in  2  ALU B select: 0 reg r2, 1 const 0, 2 const 1, 3 imm[WORD-1:0]
- selr  in  3  writeback select: 0 mem_rd low, 1 mem_rd high, 2 alu_r, 3 alu_rhi, 4 imm, 5 com_rd, 6 intr_flag; others → alu_r
- isize  in  2  instruction length − 1 (0..3 → 1..4)
- pc_op  in  3  0 SEQ, 1 BR (relative, if br_take), 2 JMP, 3 CALL, 4 RET, 5 RETI; others SEQ
- br_take  in  1  branch condition from control
- carry_upd  in  1  latch alu_cout into carry
- imm  in  IMMW  immediate
- alu_a, alu_b  out  WORD  ALU operands
- alu_r, alu_rhi  in  WORD  ALU results
- alu_cout  in  1  ALU carry out
- alu_cin  out  1  carry flag
- mem_rd  in  2·WORD  memory read data
- mem_wr  out  2·WORD  {r2, r1}
- com_rd  in  WORD  COM bus read data
- pc  out  PCW  program counter
- intr_ack  out  1  one-cycle interrupt entry pulse
- in_isr  out  1  inside service routine
- stk_err  out  1  sticky stack over/underflow

## Operation
- Register file: NREG×WORD; two combinational reads; write at edge when rw_en. A same-cycle read of a3 returns the old value. alu_a = r1.
- seq = pc + isize + 1, modulo 2^PCW.
- PC next:
  - SEQ: seq.
  - BR: br_take ? seq + sext(imm[15:0]) (truncated to PCW) : seq.
  - JMP: imm[PCW-1:0].
  - CALL: push seq, then pc ← imm[PCW-1:0]. If stack full: stk_err ← 1, push dropped, jump still taken.
  - RET: pop into pc. If stack empty: stk_err ← 1, pc ← seq.
  - RETI: pc ← saved_pc, carry ← saved_carry, in_isr ← 0.
- Stack pointer wraps never; depth is tracked with a count 0..STACK_DEPTH.
- Carry: on edge with carry_upd, carry ← alu_cout.
- Interrupt entry fires when interrupt=1, in_isr=0, and pc_op≠RETI. In that cycle:
  - the current instruction completes (register write and carry update happen);
  - saved_pc ← the PC next computed above (including stack effects);
  - saved_carry ← post-update carry;
  - intr_flag ← com_rd;
  - pc ← INTR_VEC; in_isr ← 1; intr_ack = 1 for that cycle.
- No nesting: interrupt is ignored while in_isr=1.
- RETI with in_isr=0: treated as RET-free return to saved_pc, and stk_err ← 1.

## Timing
- Single-cycle: all state updates on the edge at which the instruction is presented; no stalls.
- Reset (rst=0 at edge) clears: pc, registers, carry, stack count, saved_pc, saved_carry, intr_flag, in_isr, stk_err. intr_ack = 0 during reset.
- Reset overrides everything in the same cycle, including a pending interrupt or CALL.
- stk_err clears only on reset.

## Configuration
- DATAPATH_INTR_EN defined: interrupt logic as above.
- Not defined:
  - interrupt ignored; intr_ack and in_isr tied 0;
  - selr=6 writes 0;
  - RETI behaves as SEQ;
  - no saved_pc/saved_carry/intr_flag state.

## Test plan
- Reset: hold rst=0 two cycles with rw_en=1, pc_op=JMP → pc=0, all regs 0, stk_err=0, intr_ack=0.
- Sequential/branch (PCW=16): pc=0x00FE, isize=1 → pc=0x0100; then BR, br_take=1, imm=16'hFFFC, isize=1 → 0x00FE; br_take=0 → 0x0102.
- Return stack: STACK_DEPTH=4, five CALLs to 0x0200 from pc 0x10, isize=2 → fifth sets stk_err=1; four RETs return 0x0203 ×3 then 0x0013; fifth RET → pc=seq, stk_err stays 1.
- Interrupt: at pc=0x0040 executing SEQ isize=0 with carry_upd=1, alu_cout=1, com_rd=0x5A, interrupt=1:
  - pc=0x0010, intr_ack pulse, in_isr=1;
  - selr=6 writes 0x5A;
  - RETI → pc=0x0041, carry=1, in_isr=0.
- Interrupt held high during ISR → no re-entry until after RETI; re-entry on the next instruction after RETI.
- Register hazard: write 0xA5 to r2 while reading r2 → old value on alu_b; next cycle 0xA5. With selb=3, imm=0x1C7 → alu_b=0xC7 (WORD=8).
